// File: rtl/imem_line_responder.sv
// imem_line_responder: single-line (256-bit) instruction buffer answering fetch requests.
// Latency: hit -> response 1 cycle after acceptance; miss -> response 1 cycle after the 4th burst beat.
// Backpressure: holds in REQ while bmem_ready=0; new requests are only taken in IDLE with no response pending.
// Ports: clk/rst; fetch side imem_addr/imem_rmask in, imem_rdata/imem_resp out; branch_mispredict cancel;
//        burst side bmem_addr/bmem_read out, bmem_ready/bmem_rdata/bmem_rvalid in.
module imem_line_responder #(
    parameter int BEATS      = 4,
    parameter int BEAT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_mispredict,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    input  logic        bmem_ready,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    localparam int LINE_W = BEATS * BEAT_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t              state_q;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   fill_line;
    logic [26:0]         tag_q;
    logic                line_valid_q;
    logic                kill_q;
    logic [1:0]          beat_cnt_q;
    logic                resp_q;
    logic [31:0]         rdata_q;
    logic [31:0]         bmem_addr_q;
    logic [31:2]         req_addr_q;

    logic hit;
    logic req_ok;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^imem_addr[1:0];

    assign hit    = line_valid_q && (tag_q == imem_addr[31:5]);
    // A pending response (resp_q) or a same-cycle mispredict blocks acceptance.
    assign req_ok = (state_q == IDLE) && (imem_rmask != 4'b0) && !resp_q && !branch_mispredict;

    // Line as it will look once the current beat is written; lets the last beat
    // feed the response word on the same edge it is captured.
    always_comb begin
        fill_line = line_q;
        fill_line[{beat_cnt_q, 6'b0} +: 64] = bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_q       <= '0;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
            kill_q       <= 1'b0;
            beat_cnt_q   <= '0;
            resp_q       <= 1'b0;
            rdata_q      <= '0;
            bmem_addr_q  <= '0;
            req_addr_q   <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_ok) begin
                        if (hit) begin
                            resp_q  <= 1'b1;
                            rdata_q <= line_q[{imem_addr[4:2], 5'b0} +: 32];
                        end else begin
                            req_addr_q   <= imem_addr[31:2];
                            bmem_addr_q  <= {imem_addr[31:5], 5'b0};
                            // The buffer is about to be overwritten beat by beat.
                            line_valid_q <= 1'b0;
                            state_q      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (branch_mispredict) begin
                        state_q <= IDLE;
                    end else if (bmem_ready) begin
                        beat_cnt_q <= '0;
                        kill_q     <= 1'b0;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    // A cancelled fill is still drained so the burst stays in sync.
                    if (branch_mispredict) begin
                        kill_q <= 1'b1;
                    end
                    if (bmem_rvalid) begin
                        line_q     <= fill_line;
                        beat_cnt_q <= beat_cnt_q + 2'd1;
                        if (beat_cnt_q == 2'd3) begin
                            line_valid_q <= 1'b1;
                            tag_q        <= req_addr_q[31:5];
                            state_q      <= IDLE;
                            resp_q       <= ~(kill_q | branch_mispredict);
                            rdata_q      <= fill_line[{req_addr_q[4:2], 5'b0} +: 32];
                            kill_q       <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_rdata = rdata_q;
    assign imem_resp  = resp_q & ~branch_mispredict;
    assign bmem_addr  = bmem_addr_q;
    assign bmem_read  = (state_q == REQ) && bmem_ready && !branch_mispredict;

endmodule

// File: tb/tb_imem_line_responder.sv
// tb_imem_line_responder: directed bench with a response scoreboard for imem_line_responder.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Burst memory contents come from a small address-derived model.
module tb_imem_line_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_mispredict;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    always #5 clk = ~clk;

    imem_line_responder dut (
        .clk               (clk),
        .rst               (rst),
        .branch_mispredict (branch_mispredict),
        .imem_addr         (imem_addr),
        .imem_rmask        (imem_rmask),
        .imem_rdata        (imem_rdata),
        .imem_resp         (imem_resp),
        .bmem_addr         (bmem_addr),
        .bmem_read         (bmem_read),
        .bmem_ready        (bmem_ready),
        .bmem_rdata        (bmem_rdata),
        .bmem_rvalid       (bmem_rvalid)
    );

    int          passes = 0;
    int          total  = 0;
    int          resp_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] sb[$];

    // Word i of line L in the burst-memory model.
    function automatic logic [31:0] wd(input logic [31:0] line, input int i);
        logic [31:0] k;
        k = i;
        return (k * 32'h11111111) ^ (line - 32'h1ECEB000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One cycle: sample outputs at the falling edge, return just after the next rising edge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (imem_resp) begin
            resp_cnt++;
            imem_rmask = 4'h0;
            if (sb.size() == 0) begin
                chk("spurious_resp", {31'b0, imem_resp}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", imem_rdata, e);
            end
        end
        if (bmem_read) begin
            rd_cnt++;
            rd_addr = bmem_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] addr, input bit push);
        imem_addr  = addr;
        imem_rmask = 4'hF;
        if (push) sb.push_back(wd({addr[31:5], 5'b0}, int'(addr[4:2])));
    endtask

    task automatic wait_read(input string tag, input int bound);
        int base = rd_cnt;
        int n = 0;
        while (rd_cnt == base && n < bound) begin
            tick();
            n++;
        end
        chk(tag, rd_cnt, base + 1);
    endtask

    task automatic beat(input logic [31:0] line, input int b, input logic mp);
        bmem_rvalid       = 1'b1;
        bmem_rdata        = {wd(line, 2*b+1), wd(line, 2*b)};
        branch_mispredict = mp;
        tick();
        bmem_rvalid       = 1'b0;
        branch_mispredict = 1'b0;
    endtask

    task automatic miss_full(input string tag, input logic [31:0] addr);
        logic [31:0] line;
        int base;
        line = {addr[31:5], 5'b0};
        base = resp_cnt;
        req(addr, 1'b1);
        wait_read({tag, "_read"}, 10);
        chk({tag, "_baddr"}, rd_addr, line);
        for (int b = 0; b < 4; b++) beat(line, b, 1'b0);
        chk({tag, "_no_early_resp"}, resp_cnt, base);
        tick();
        chk({tag, "_resp_lat"}, resp_cnt, base + 1);
    endtask

    task automatic hit_req(input string tag, input logic [31:0] addr);
        int base = resp_cnt;
        int rb = rd_cnt;
        req(addr, 1'b1);
        tick();
        chk({tag, "_no_early_resp"}, resp_cnt, base);
        tick();
        chk({tag, "_resp_lat"}, resp_cnt, base + 1);
        chk({tag, "_no_bmem_read"}, rd_cnt, rb);
    endtask

    initial begin
        int base;
        int rb;
        rst               = 1'b1;
        branch_mispredict = 1'b0;
        imem_addr         = '0;
        imem_rmask        = '0;
        bmem_ready        = 1'b1;
        bmem_rdata        = '0;
        bmem_rvalid       = 1'b0;
        repeat (3) tick();
        chk("rst_resp",  {31'b0, imem_resp}, 32'd0);
        chk("rst_rdata", imem_rdata, 32'd0);
        chk("rst_read",  {31'b0, bmem_read}, 32'd0);
        chk("rst_baddr", bmem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss, then hits in the installed line.
        miss_full("miss1", 32'h1ECEB004);
        chk("miss1_reads", rd_cnt, 1);
        hit_req("hit1c", 32'h1ECEB01C);
        hit_req("hit08", 32'h1ECEB008);

        // Miss under bmem_ready=0.
        bmem_ready = 1'b0;
        rb = rd_cnt;
        base = resp_cnt;
        req(32'h1ECEB020, 1'b1);
        repeat (5) tick();
        chk("stall_no_read", rd_cnt, rb);
        bmem_ready = 1'b1;
        wait_read("stall_read", 3);
        chk("stall_baddr", rd_addr, 32'h1ECEB020);
        for (int b = 0; b < 4; b++) beat(32'h1ECEB020, b, 1'b0);
        tick();
        chk("stall_resp", resp_cnt, base + 1);
        miss_full("remiss00", 32'h1ECEB000);

        // Mispredict during FILL: burst drained and installed, no response.
        base = resp_cnt;
        req(32'h1ECEB040, 1'b0);
        wait_read("kill_read", 10);
        beat(32'h1ECEB040, 0, 1'b0);
        beat(32'h1ECEB040, 1, 1'b0);
        imem_rmask = 4'h0;
        beat(32'h1ECEB040, 2, 1'b1);
        beat(32'h1ECEB040, 3, 1'b0);
        repeat (3) tick();
        chk("kill_no_resp", resp_cnt, base);
        hit_req("kill_hit", 32'h1ECEB044);

        // Mispredict in REQ with bmem_ready=0: back to IDLE without a read.
        bmem_ready = 1'b0;
        rb = rd_cnt;
        req(32'h1ECEB060, 1'b0);
        tick();
        imem_rmask        = 4'h0;
        branch_mispredict = 1'b1;
        tick();
        branch_mispredict = 1'b0;
        bmem_ready        = 1'b1;
        repeat (3) tick();
        chk("reqkill_no_read", rd_cnt, rb);
        miss_full("reqkill_miss", 32'h1ECEB060);

        // Reset in the middle of a fill, then stray beats.
        base = resp_cnt;
        req(32'h1ECEB080, 1'b0);
        wait_read("rstfill_read", 10);
        beat(32'h1ECEB080, 0, 1'b0);
        beat(32'h1ECEB080, 1, 1'b0);
        rst        = 1'b1;
        imem_rmask = 4'h0;
        tick();
        rst = 1'b0;
        beat(32'h1ECEB080, 2, 1'b0);
        beat(32'h1ECEB080, 3, 1'b0);
        chk("rstfill_resp",  {31'b0, imem_resp}, 32'd0);
        chk("rstfill_rdata", imem_rdata, 32'd0);
        chk("rstfill_read",  {31'b0, bmem_read}, 32'd0);
        chk("rstfill_baddr", bmem_addr, 32'd0);
        repeat (2) tick();
        chk("rstfill_no_resp", resp_cnt, base);
        miss_full("rstfill_miss", 32'h1ECEB084);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
